// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared state, opcode, ALU and immediate encodings for the multicycle control
package riscv_ctrl_pkg;

    // Multicycle control states; codes 11-15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    // Internal ALU operation class handed from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // Supported opcodes
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate formats for the sign extender
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, so it is valid in every state
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   imm_src_of = IMM_S;
            OP_BEQ:  imm_src_of = IMM_B;
            OP_JAL:  imm_src_of = IMM_J;
            default: imm_src_of = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALU op class and instruction fields to an ALU control code
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [2:0] o_alu_control
);

    // Subtract only for R-type (op[5]=1) with funct7b5; addi ignores funct7b5
    logic w_rtype_sub;
    assign w_rtype_sub = i_op5 & i_funct7b5;

    // Decode the ALU operation from the op class and, for func, from funct3
    always_comb begin
        o_alu_control = ALU_ADD;
        if (i_alu_op == ALUOP_SUB) begin
            o_alu_control = ALU_SUB;
        end else if (i_alu_op == ALUOP_FUNC) begin
            case (i_funct3)
                3'b000:  o_alu_control = w_rtype_sub ? ALU_SUB : ALU_ADD;
                3'b010:  o_alu_control = ALU_SLT;
                3'b110:  o_alu_control = ALU_OR;
                3'b111:  o_alu_control = ALU_AND;
                default: o_alu_control = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle RISC-V control FSM with Moore output decode
module mc_control_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       irWrite,
    output logic       memWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] immSrc,
    output logic [2:0] aluControl,
    output logic       illegalOp,
    output logic [3:0] state
);

    state_t     r_state;
    logic [1:0] w_alu_op;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_illegal;

    // State register; reset aborts any instruction in flight and parks in FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    r_state <= memReady ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXECR;
                        OP_ITYPE:     r_state <= S_EXECI;
                        OP_BEQ:       r_state <= S_BEQ;
                        OP_JAL:       r_state <= S_JAL;
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    if (op == OP_LW)      r_state <= S_MEMREAD;
                    else if (op == OP_SW) r_state <= S_MEMWRITE;
                    else                  r_state <= S_FETCH;
                end
                S_MEMREAD:  r_state <= memReady ? S_MEMWB : S_MEMREAD;
                S_MEMWRITE: r_state <= memReady ? S_FETCH : S_MEMWRITE;
                S_EXECR:    r_state <= S_ALUWB;
                S_EXECI:    r_state <= S_ALUWB;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // Moore decode of the current state; only FETCH and BEQ strobes look at inputs
    always_comb begin
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        adrSrc      = 1'b0;
        resultSrc   = 2'b00;
        aluSrcA     = 2'b00;
        aluSrcB     = 2'b00;
        w_alu_op    = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                aluSrcB    = 2'b10;
                resultSrc  = 2'b10;
                w_ir_write = memReady;
                w_pc_write = memReady;
            end
            S_DECODE: begin
                aluSrcA   = 2'b01;
                aluSrcB   = 2'b01;
                w_illegal = !(op == OP_LW || op == OP_SW || op == OP_RTYPE ||
                              op == OP_ITYPE || op == OP_BEQ || op == OP_JAL);
            end
            S_MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
            end
            S_MEMREAD: begin
                adrSrc = 1'b1;
            end
            S_MEMWB: begin
                resultSrc   = 2'b01;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                aluSrcA  = 2'b10;
                w_alu_op = ALUOP_FUNC;
            end
            S_EXECI: begin
                aluSrcA  = 2'b10;
                aluSrcB  = 2'b01;
                w_alu_op = ALUOP_FUNC;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
            end
            S_BEQ: begin
                aluSrcA    = 2'b10;
                w_alu_op   = ALUOP_SUB;
                w_pc_write = zero;
            end
            S_JAL: begin
                aluSrcA    = 2'b01;
                aluSrcB    = 2'b10;
                w_pc_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Strobes are suppressed while reset is held, even though FETCH follows memReady
    assign pcWrite   = w_pc_write  & rst_n;
    assign irWrite   = w_ir_write  & rst_n;
    assign memWrite  = w_mem_write & rst_n;
    assign regWrite  = w_reg_write & rst_n;
    assign illegalOp = w_illegal   & rst_n;
    assign immSrc    = imm_src_of(op);
    assign state     = r_state;

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_op5         (op[5]),
        .o_alu_control (aluControl)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed-vector bench for mc_control_fsm
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       memReady;
    logic       pcWrite, adrSrc, irWrite, memWrite, regWrite;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
    logic [2:0] aluControl;
    logic       illegalOp;
    logic [3:0] state;

    int n_vec = 0;
    int n_err = 0;

    mc_control_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .memReady   (memReady),
        .pcWrite    (pcWrite),
        .adrSrc     (adrSrc),
        .irWrite    (irWrite),
        .memWrite   (memWrite),
        .regWrite   (regWrite),
        .resultSrc  (resultSrc),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .immSrc     (immSrc),
        .aluControl (aluControl),
        .illegalOp  (illegalOp),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Strobe bundle {pcWrite, irWrite, memWrite, regWrite, illegalOp}
    function automatic logic [4:0] strobes();
        return {pcWrite, irWrite, memWrite, regWrite, illegalOp};
    endfunction

    initial begin
        rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0;
        zero = 1'b0; memReady = 1'b1;
        #2;
        check_vec("rst_state", state, 4'd0);
        check_vec("rst_strobes", strobes(), 5'b00000);
        check_vec("rst_alusrcb", aluSrcB, 2'b10);
        check_vec("rst_resultsrc", resultSrc, 2'b10);
        cyc();
        cyc();
        check_vec("rst_hold_state", state, 4'd0);
        rst_n = 1'b1;

        // FETCH holds while memory is not ready
        memReady = 1'b0; #1;
        check_vec("fetch_wait_ir", irWrite, 1'b0);
        cyc();
        check_vec("fetch_wait_state", state, 4'd0);

        // lw: 0,1,2,3,4,0
        memReady = 1'b1; op = 7'b0000011; #1;
        check_vec("lw_fetch_strobes", strobes(), 5'b11000);
        check_vec("lw_imm", immSrc, 2'b00);
        cyc(); #1;
        check_vec("lw_s1", state, 4'd1);
        check_vec("lw_dec_srca", aluSrcA, 2'b01);
        check_vec("lw_dec_strobes", strobes(), 5'b00000);
        cyc(); #1;
        check_vec("lw_s2", state, 4'd2);
        check_vec("lw_memadr_srca", aluSrcA, 2'b10);
        cyc(); #1;
        check_vec("lw_s3", state, 4'd3);
        check_vec("lw_memread_adr", adrSrc, 1'b1);
        check_vec("lw_memread_strobes", strobes(), 5'b00000);
        cyc(); #1;
        check_vec("lw_s4", state, 4'd4);
        check_vec("lw_wb_strobes", strobes(), 5'b00010);
        check_vec("lw_wb_result", resultSrc, 2'b01);
        cyc(); #1;
        check_vec("lw_done", state, 4'd0);

        // sw with two wait cycles in MEMWRITE
        op = 7'b0100011; #1;
        check_vec("sw_imm", immSrc, 2'b01);
        cyc(); cyc(); #1;
        check_vec("sw_s2", state, 4'd2);
        cyc();
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) memReady = 1'b1;
            #1;
            check_vec($sformatf("sw_memwrite_%0d", i), {state, memWrite}, {4'd5, 1'b1});
            cyc();
        end
        #1;
        check_vec("sw_done", {state, memWrite}, {4'd0, 1'b0});

        // beq taken then not taken
        for (int z = 1; z >= 0; z--) begin
            op = 7'b1100011; zero = z[0]; #1;
            check_vec("beq_imm", immSrc, 2'b10);
            cyc(); cyc(); #1;
            check_vec("beq_state", state, 4'd9);
            check_vec($sformatf("beq_pcwrite_z%0d", z), pcWrite, z[0]);
            check_vec("beq_aluctl", aluControl, 3'b001);
            cyc(); #1;
            check_vec("beq_done", state, 4'd0);
        end
        zero = 1'b0;

        // R-type sub
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        cyc(); cyc(); #1;
        check_vec("rsub_state", state, 4'd6);
        check_vec("rsub_aluctl", aluControl, 3'b001);
        cyc(); #1;
        check_vec("rsub_aluwb", {state, regWrite}, {4'd8, 1'b1});
        cyc(); #1;
        check_vec("rsub_done", state, 4'd0);

        // R-type slt
        funct3 = 3'b010; funct7b5 = 1'b0;
        cyc(); cyc(); #1;
        check_vec("rslt_aluctl", aluControl, 3'b101);
        cyc(); cyc();

        // I-type addi with funct7b5 set still adds
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
        cyc(); cyc(); #1;
        check_vec("addi_state", state, 4'd7);
        check_vec("addi_aluctl", aluControl, 3'b000);
        cyc(); cyc(); #1;
        check_vec("addi_done", state, 4'd0);

        // ori (funct3 110) and andi (funct3 111)
        funct3 = 3'b110; funct7b5 = 1'b0;
        cyc(); cyc(); #1;
        check_vec("ori_aluctl", aluControl, 3'b011);
        cyc(); cyc();
        funct3 = 3'b111;
        cyc(); cyc(); #1;
        check_vec("andi_aluctl", aluControl, 3'b010);
        cyc(); cyc();
        funct3 = 3'b000;

        // jal
        op = 7'b1101111; #1;
        check_vec("jal_imm", immSrc, 2'b11);
        cyc(); cyc(); #1;
        check_vec("jal_state", state, 4'd10);
        check_vec("jal_pcwrite", pcWrite, 1'b1);
        cyc(); #1;
        check_vec("jal_done", state, 4'd0);

        // illegal opcode
        op = 7'b1111111;
        cyc(); #1;
        check_vec("ill_decode", {state, illegalOp}, {4'd1, 1'b1});
        memReady = 1'b0;
        cyc(); #1;
        check_vec("ill_fetch_state", state, 4'd0);
        check_vec("ill_fetch_strobes", strobes(), 5'b00000);

        // reset during MEMREAD
        memReady = 1'b1; op = 7'b0000011;
        cyc(); cyc();
        memReady = 1'b0;
        cyc(); #1;
        check_vec("rstmid_pre", state, 4'd3);
        #1; rst_n = 1'b0; #1;
        check_vec("rstmid_state", state, 4'd0);
        check_vec("rstmid_strobes", strobes(), 5'b00000);
        cyc();
        rst_n = 1'b1; memReady = 1'b1;
        cyc(); #1;
        check_vec("rstmid_resume", state, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameters: none; all encodings are fixed constants.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 op  in  7  instruction opcode, from the instruction register.
REQ-005 funct3  in  3  instruction bits [14:12].
REQ-006 funct7b5  in  1  instruction bit 30.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 memReady  in  1  memory completes the current access this cycle.
REQ-009 pcWrite, adrSrc, irWrite, memWrite, regWrite  out  1 each  datapath strobes and selects.
REQ-010 resultSrc, aluSrcA, aluSrcB  out  2 each  mux selects.
REQ-011 immSrc  out  2  immediate format for the sign extender: 00=I, 01=S, 10=B, 11=J.
REQ-012 aluControl  out  3  ALU op: 000=add, 001=sub, 010=and, 011=or, 101=slt.
REQ-013 illegalOp  out  1  unsupported opcode seen in DECODE.
REQ-014 state  out  4  current state, for debug.

Function
REQ-015 The FSM SHALL use states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-016 Transitions SHALL be:
- FETCH->DECODE when memReady=1, else hold.
- DECODE->MEMADR (0000011 lw, 0100011 sw), EXECR (0110011), EXECI (0010011), BEQ (1100011), JAL (1101111); any other opcode->FETCH.
- MEMADR->MEMREAD for lw, MEMWRITE for sw.
- MEMREAD->MEMWB when memReady=1, else hold.
- MEMWRITE->FETCH when memReady=1, else hold.
- MEMWB, ALUWB, BEQ, JAL->FETCH.
- EXECR, EXECI->ALUWB.
REQ-017 Outputs SHALL be Moore decodes of state, except the memReady-gated and zero-gated strobes named below; unlisted outputs are 0.
- FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, resultSrc=10, aluOp add; irWrite=pcWrite=memReady.
- DECODE: aluSrcA=01, aluSrcB=01, aluOp add.
- MEMADR: aluSrcA=10, aluSrcB=01, aluOp add.
- MEMREAD: adrSrc=1, resultSrc=00.
- MEMWB: resultSrc=01, regWrite=1.
- MEMWRITE: adrSrc=1, resultSrc=00, memWrite=1 held for every cycle until memReady.
- EXECR: aluSrcA=10, aluSrcB=00, aluOp func.
- EXECI: aluSrcA=10, aluSrcB=01, aluOp func.
- ALUWB: resultSrc=00, regWrite=1.
- BEQ: aluSrcA=10, aluSrcB=00, aluOp sub, resultSrc=00, pcWrite=zero.
- JAL: aluSrcA=01, aluSrcB=10, resultSrc=00, pcWrite=1.
REQ-018 immSrc SHALL decode combinationally from op in every state: lw/I-ALU->00, sw->01, beq->10, jal->11, other->00.
REQ-019 aluControl SHALL be:
- aluOp add -> 000; aluOp sub -> 001.
- aluOp func, by funct3: 000 -> sub if op[5]&funct7b5 else add; 010 -> 101; 110 -> 011; 111 -> 010; other funct3 -> 000.
REQ-020 illegalOp SHALL be 1 only in the DECODE cycle holding an unsupported opcode.
REQ-021 Each instruction SHALL take exactly: lw 5, sw 4, R/I 4, beq 3, jal 3 cycles, plus one cycle per memReady=0 wait cycle.

Reset
REQ-022 rst_n=0 SHALL force state to FETCH immediately, independent of clk.
REQ-023 While rst_n=0, pcWrite, irWrite, memWrite, regWrite and illegalOp SHALL be 0; other outputs SHALL take their FETCH values.
REQ-024 Reset asserted mid-instruction SHALL abort it; after release, the first rising edge SHALL evaluate FETCH.

Structure
REQ-025 State codes, opcode constants and aluControl codes SHALL live in a shared package, riscv_ctrl_pkg, so the datapath and the sign-extender stimulus reuse them.
REQ-026 The ALU decoder (aluOp, funct3, funct7b5, op[5] -> aluControl) SHALL be a sub-module, alu_decoder; the FSM and output decode SHALL stay in mc_control_fsm.

Verification
REQ-027 lw (op=0000011), memReady=1 throughout -> states 0,1,2,3,4,0; regWrite=1 only in the state-4 cycle; immSrc=00.
REQ-028 sw (op=0100011), memReady=0 for 2 cycles in MEMWRITE -> memWrite=1 for 3 consecutive cycles, then FETCH; immSrc=01.
REQ-029 beq (op=1100011) with zero=1 then with zero=0 -> pcWrite=1 in BEQ, then pcWrite=0 in BEQ; aluControl=001; immSrc=10.
REQ-030 R-type sub (op=0110011, funct3=000, funct7b5=1) -> aluControl=001 in EXECR; I-type addi with funct7b5=1 -> aluControl=000.
REQ-031 op=1111111 -> illegalOp=1 for one cycle in DECODE, then FETCH with no strobes asserted.
REQ-032 rst_n pulled low during MEMREAD -> state=0 and all strobes 0 within the same cycle; FETCH resumes on the first edge after release.
